// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared types and helpers for the intersection phase scheduler.
// The state enum, lamp bit positions and a one-hot helper.
package traffic_sched_pkg;

    localparam int MAX_APPR = 8;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        ORANGE  = 2'd2,
        WALK    = 2'd3
    } state_e;

    localparam int LAMP_RED    = 0;
    localparam int LAMP_ORANGE = 1;
    localparam int LAMP_GREEN  = 2;
    localparam int N_LAMP      = 3;

    function automatic logic [MAX_APPR-1:0] onehot(input logic [2:0] idx);
        return MAX_APPR'(1) << idx;
    endfunction

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Detector inputs and lamp outputs of the phase scheduler.
// The controller side is the slave; the detector/lamp side is the master.
interface intersection_phase_scheduler_if #(
    parameter int N_APPR = 4
);
    localparam int PW = $clog2(N_APPR);

    logic [N_APPR-1:0] req;
    logic              ped_req;
    logic [N_APPR-1:0] green;
    logic [N_APPR-1:0] orange;
    logic [N_APPR-1:0] red;
    logic              walk;
    logic [PW-1:0]     phase_idx;
    logic              ped_pending;

    modport master (
        output req, ped_req,
        input  green, orange, red, walk, phase_idx, ped_pending
    );

    modport slave (
        input  req, ped_req,
        output green, orange, red, walk, phase_idx, ped_pending
    );

endinterface

// File: rtl/intersection_phase_scheduler_rr_pick.sv
// Circular first-requester search starting at ptr (combinational).
// Scanning offsets from high to low lets the lowest offset win.
module rr_pick #(
    parameter int N_APPR = 4,
    parameter int PW     = $clog2(N_APPR)
) (
    input  logic [N_APPR-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic              vld,
    output logic [PW-1:0]     idx
);

    int            s;
    logic [PW-1:0] sel;

    always_comb begin
        vld = 1'b0;
        idx = '0;
        s   = 0;
        sel = '0;
        for (int k = N_APPR - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= N_APPR) s = s - N_APPR;
            sel = PW'(s);
            if (req[sel]) begin
                vld = 1'b1;
                idx = sel;
            end
        end
    end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Round-robin intersection sequencer: green/orange/all-red per approach,
// plus an exclusive pedestrian walk phase. Lamps are registered from next state.
module intersection_phase_scheduler
    import traffic_sched_pkg::*;
#(
    parameter int N_APPR      = 4,
    parameter int CW          = 6,
    parameter int T_GREEN_MIN = 8,
    parameter int T_GREEN_MAX = 25,
    parameter int T_ORANGE    = 5,
    parameter int T_ALLRED    = 2,
    parameter int T_WALK      = 10
) (
    input  logic clk,
    input  logic rst,
    intersection_phase_scheduler_if.slave bus
);

    localparam int PW = $clog2(N_APPR);

    localparam logic [1:0] ST_ALL_RED = ALL_RED;
    localparam logic [1:0] ST_GREEN   = GREEN;
    localparam logic [1:0] ST_ORANGE  = ORANGE;
    localparam logic [1:0] ST_WALK    = WALK;

    if (N_APPR < 2 || N_APPR > MAX_APPR) begin : g_chk_n
        $error("N_APPR must be in 2..8");
    end
    if (T_GREEN_MIN < 1 || T_GREEN_MAX < T_GREEN_MIN || T_GREEN_MAX >= (1 << CW)) begin : g_chk_green
        $error("green timing out of range");
    end
    if (T_ORANGE < 1 || T_ALLRED < 1 || T_WALK < 1 ||
        T_ORANGE > (1 << CW) || T_ALLRED > (1 << CW) || T_WALK > (1 << CW)) begin : g_chk_phase
        $error("phase timing out of range");
    end

    logic [1:0]    state, nstate;
    logic [CW-1:0] timer, ntimer;
    logic [PW-1:0] ptr, nptr, cur, ncur;
    logic          ped_pend, enter_walk;
    logic          pick_vld;
    logic [PW-1:0] pick_idx;
    logic          green_done;

    logic [MAX_APPR-1:0] req_w, cur_oh;

    logic [N_APPR-1:0][N_LAMP-1:0] lamp_d, lamp_q;
    logic                          walk_q;
    logic [N_APPR-1:0]             g_vec, o_vec, r_vec;

    rr_pick #(.N_APPR(N_APPR), .PW(PW)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    assign req_w  = MAX_APPR'(bus.req);
    assign cur_oh = onehot(3'(cur));

    // Below the minimum only the max-length cap can end green; above it, any loss of
    // own demand, competing demand, or a pending pedestrian ends it.
    assign green_done = (timer == CW'(T_GREEN_MAX - 1)) ||
                        ((timer >= CW'(T_GREEN_MIN - 1)) &&
                         (((req_w & cur_oh) == '0) || ((req_w & ~cur_oh) != '0) || ped_pend));

    always_comb begin
        nstate     = state;
        ntimer     = timer;
        nptr       = ptr;
        ncur       = cur;
        enter_walk = 1'b0;
        case (state)
            ST_ALL_RED: begin
                if (timer != '0) begin
                    ntimer = timer - 1'b1;
                end else if (ped_pend) begin
                    nstate     = ST_WALK;
                    ntimer     = CW'(T_WALK - 1);
                    enter_walk = 1'b1;
                end else if (pick_vld) begin
                    nstate = ST_GREEN;
                    ntimer = '0;
                    ncur   = pick_idx;
                    nptr   = (pick_idx == PW'(N_APPR - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            ST_GREEN: begin
                if (green_done) begin
                    nstate = ST_ORANGE;
                    ntimer = CW'(T_ORANGE - 1);
                end else begin
                    ntimer = timer + 1'b1;
                end
            end
            ST_ORANGE: begin
                if (timer == '0) begin
                    nstate = ST_ALL_RED;
                    ntimer = CW'(T_ALLRED - 1);
                end else begin
                    ntimer = timer - 1'b1;
                end
            end
            default: begin
                if (timer == '0) begin
                    nstate = ST_ALL_RED;
                    ntimer = CW'(T_ALLRED - 1);
                end else begin
                    ntimer = timer - 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        lamp_d = '0;
        for (int i = 0; i < N_APPR; i++) begin
            lamp_d[i][LAMP_GREEN]  = (nstate == ST_GREEN)  && (ncur == PW'(i));
            lamp_d[i][LAMP_ORANGE] = (nstate == ST_ORANGE) && (ncur == PW'(i));
            lamp_d[i][LAMP_RED]    = !(lamp_d[i][LAMP_GREEN] || lamp_d[i][LAMP_ORANGE]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_ALL_RED;
            timer    <= CW'(T_ALLRED - 1);
            ptr      <= '0;
            cur      <= '0;
            ped_pend <= 1'b0;
            walk_q   <= 1'b0;
            for (int i = 0; i < N_APPR; i++) lamp_q[i] <= N_LAMP'(1) << LAMP_RED;
        end else begin
            state    <= nstate;
            timer    <= ntimer;
            ptr      <= nptr;
            cur      <= ncur;
            ped_pend <= bus.ped_req | (ped_pend & ~enter_walk);
            walk_q   <= (nstate == ST_WALK);
            lamp_q   <= lamp_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_APPR; i++) begin
            g_vec[i] = lamp_q[i][LAMP_GREEN];
            o_vec[i] = lamp_q[i][LAMP_ORANGE];
            r_vec[i] = lamp_q[i][LAMP_RED];
        end
    end

    assign bus.green       = g_vec;
    assign bus.orange      = o_vec;
    assign bus.red         = r_vec;
    assign bus.walk        = walk_q;
    assign bus.phase_idx   = cur;
    assign bus.ped_pending = ped_pend;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench for intersection_phase_scheduler: a phase-level reference model
// predicts lamps per cycle; a monitor pops predictions and also logs green/walk runs.
module tb_intersection_phase_scheduler;

    localparam int N    = 4;
    localparam int GMIN = 8;
    localparam int GMAX = 25;
    localparam int TOR  = 5;
    localparam int TAR  = 2;
    localparam int TWK  = 10;

    localparam int K_AR = 0, K_G = 1, K_O = 2, K_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    intersection_phase_scheduler_if #(.N_APPR(N)) bus ();

    intersection_phase_scheduler #(
        .N_APPR(N), .CW(6), .T_GREEN_MIN(GMIN), .T_GREEN_MAX(GMAX),
        .T_ORANGE(TOR), .T_ALLRED(TAR), .T_WALK(TWK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [N-1:0] g, o, r;
        logic         w;
        logic [1:0]   pi;
        logic         pp;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   started = 0;

    // phase-level model: kind, served approach, cycles already spent in the phase
    int m_kind, m_appr, m_el, m_ptr;
    bit m_pend;

    int glen_q[$], gidx_q[$], wlen_q[$];
    int g_run, w_run;
    logic [N-1:0] prev_g;
    logic prev_w;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int phase_len(input int kind);
        case (kind)
            K_AR:    return TAR;
            K_O:     return TOR;
            K_W:     return TWK;
            default: return GMAX;
        endcase
    endfunction

    task automatic model_reset();
        m_kind = K_AR; m_appr = 0; m_el = 0; m_ptr = 0; m_pend = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input bit p);
        bit walk_entry = 0;
        bit done;
        int a;
        case (m_kind)
            K_AR: begin
                if (m_el < TAR - 1) m_el++;
                else if (m_pend) begin
                    m_kind = K_W; m_el = 0; walk_entry = 1;
                end else if (r != 0) begin
                    for (int k = 0; k < N; k++) begin
                        a = (m_ptr + k) % N;
                        if (r[a]) break;
                    end
                    m_kind = K_G; m_appr = a; m_el = 0; m_ptr = (a + 1) % N;
                end
            end
            K_G: begin
                done = (m_el == GMAX - 1) ||
                       (m_el >= GMIN - 1 && (!r[m_appr] || (r & ~(N'(1) << m_appr)) != 0 || m_pend));
                if (done) begin m_kind = K_O; m_el = 0; end
                else m_el++;
            end
            default: begin
                if (m_el == phase_len(m_kind) - 1) begin m_kind = K_AR; m_el = 0; end
                else m_el++;
            end
        endcase
        m_pend = p | (m_pend & !walk_entry);
    endtask

    task automatic push_exp();
        exp_t e;
        e.g  = (m_kind == K_G) ? N'(1) << m_appr : '0;
        e.o  = (m_kind == K_O) ? N'(1) << m_appr : '0;
        e.r  = ~(e.g | e.o);
        e.w  = (m_kind == K_W);
        e.pi = 2'(m_appr);
        e.pp = m_pend;
        q.push_back(e);
    endtask

    task automatic cycle(input logic [N-1:0] r, input bit p, input bit rs);
        @(negedge clk);
        bus.req = r; bus.ped_req = p; rst = rs;
        if (!rs) model_reset();
        else model_step(r, p);
        push_exp();
        started = 1;
    endtask

    task automatic clear_logs();
        glen_q.delete(); gidx_q.delete(); wlen_q.delete();
        g_run = 0; w_run = 0; prev_g = '0; prev_w = 0;
    endtask

    task automatic reset_seq();
        cycle('0, 0, 0);
        cycle('0, 0, 0);
        clear_logs();
    endtask

    function automatic int qget(input int qq[$], input int i);
        return (i < qq.size()) ? qq[i] : -1;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("green",       int'(bus.green),       int'(e.g));
            check("orange",      int'(bus.orange),      int'(e.o));
            check("red",         int'(bus.red),         int'(e.r));
            check("walk",        int'(bus.walk),        int'(e.w));
            check("phase_idx",   int'(bus.phase_idx),   int'(e.pi));
            check("ped_pending", int'(bus.ped_pending), int'(e.pp));
            check("exclusive",   int'($countones(bus.green | bus.orange) + (bus.walk ? 1 : 0) <= 1), 1);
        end else if (started) begin
            check("queue_empty", 0, 1);
        end
        if (bus.green != 0) begin
            if (prev_g == 0)
                for (int i = 0; i < N; i++) if (bus.green[i]) gidx_q.push_back(i);
            g_run++;
        end else if (prev_g != 0) begin
            glen_q.push_back(g_run); g_run = 0;
        end
        if (bus.walk) w_run++;
        else if (prev_w) begin wlen_q.push_back(w_run); w_run = 0; end
        prev_g = bus.green;
        prev_w = bus.walk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bus.req = '0; bus.ped_req = 0; rst = 0;
        clear_logs();

        // idle after reset
        repeat (3) cycle('0, 0, 0);
        repeat (100) cycle('0, 0, 1);
        check("t1_no_grant", gidx_q.size(), 0);

        // single constant requester runs to max green, then is re-granted
        reset_seq();
        repeat (40) cycle(4'b0001, 0, 1);
        check("t2_glen_max", qget(glen_q, 0), GMAX);
        check("t2_regrant",  qget(gidx_q, 1), 0);

        // short demand ends at min green, then rest
        reset_seq();
        for (int i = 0; i < 10 && m_kind != K_G; i++) cycle(4'b0010, 0, 1);
        check("t3_reach_green", int'(m_kind == K_G), 1);
        repeat (3) cycle(4'b0010, 0, 1);
        repeat (30) cycle('0, 0, 1);
        check("t3_glen_min", qget(glen_q, 0), GMIN);
        check("t3_idx",      qget(gidx_q, 0), 1);
        check("t3_rest",     gidx_q.size(), 1);

        // all approaches busy: round robin at min green
        reset_seq();
        repeat (75) cycle(4'b1111, 0, 1);
        for (int i = 0; i < 5; i++) check($sformatf("t4_order%0d", i), qget(gidx_q, i), i % N);
        for (int i = 0; i < 4; i++) check($sformatf("t4_glen%0d", i), qget(glen_q, i), GMIN);

        // pedestrian request during a long green
        reset_seq();
        for (int i = 0; i < 40 && !(m_kind == K_G && m_el == 11); i++) cycle(4'b0100, 0, 1);
        check("t5_reach_g12", int'(m_kind == K_G && m_el == 11), 1);
        cycle(4'b0100, 1, 1);
        repeat (45) cycle(4'b0100, 0, 1);
        check("t5_walk_len", qget(wlen_q, 0), TWK);
        check("t5_after_walk", qget(gidx_q, 1), 2);

        // reset in the middle of orange
        reset_seq();
        for (int i = 0; i < 60 && !(m_kind == K_O && m_el == 1); i++) cycle(4'b1000, 0, 1);
        check("t6_reach_orange", int'(m_kind == K_O && m_el == 1), 1);
        cycle(4'b1111, 0, 0);
        #1;
        check("t6_orange_off", int'(bus.orange), 0);
        check("t6_red_on",     int'(bus.red), 4'hf);
        cycle(4'b1111, 0, 0);
        clear_logs();
        repeat (12) cycle(4'b1111, 0, 1);
        check("t6_first_grant", qget(gidx_q, 0), 0);

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++)
            cycle(N'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 399) != 0);

        @(posedge clk);
        #2;
        check("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
